// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Oversampling UART receiver. It recovers frames made of one start bit,
//   DATA_WIDTH data bits (LSB first), an optional parity bit and one stop bit.
//   Each bit spans `prescale` clocks. The bit value is the majority of three
//   samples taken around mid-bit. A good frame gives a one-cycle data_valid
//   pulse with P_DATA updated in that cycle. A bad frame gives one error pulse
//   instead.
//
// Ports
//   CLK            in   oversampling clock (prescale x baud)
//   RST            in   asynchronous active-low reset
//   RX_IN          in   serial line, idle high, asynchronous to CLK
//   prescale       in   clocks per bit (8, 16 or 32)
//   parity_enable  in   1 = parity bit present in the frame
//   parity_type    in   0 = even, 1 = odd
//   P_DATA         out  last correctly received word
//   data_valid     out  1-cycle pulse, P_DATA updated this cycle
//   parity_error   out  1-cycle pulse, parity mismatch
//   stop_error     out  1-cycle pulse, stop bit sampled low
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [1:0]            sync_q;
    logic [2:0]            state_q,    state_d;
    logic [PRESC_W-1:0]    edge_q,     edge_d;
    logic [BCW-1:0]        bit_q,      bit_d;
    logic [PRESC_W-1:0]    presc_q,    presc_d;
    logic                  par_en_q,   par_en_d;
    logic                  par_type_q, par_type_d;
    logic [1:0]            samp_q,     samp_d;
    logic                  start_v_q,  start_v_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic                  par_flag_q, par_flag_d;
    logic [DATA_WIDTH-1:0] pdata_q,    pdata_d;
    logic                  dv_q,       dv_d;
    logic                  pe_q,       pe_d;
    logic                  se_q,       se_d;

    logic                  rx_s;
    logic [PRESC_W-1:0]    half;
    logic                  at_s0, at_s1, at_s2, last_edge;
    logic                  vote;

    assign rx_s      = sync_q[1];
    assign half      = presc_q >> 1;
    assign at_s0     = (edge_q == half - PRESC_W'(1));
    assign at_s1     = (edge_q == half);
    assign at_s2     = (edge_q == half + PRESC_W'(1));
    assign last_edge = (edge_q == presc_q - PRESC_W'(1));

    // The third sample is the live synchronized line at the third sample
    // point, so the vote is ready in that same cycle.
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    always_comb begin
        state_d    = state_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        samp_d     = samp_q;
        start_v_d  = start_v_q;
        shift_d    = shift_q;
        par_flag_d = par_flag_q;
        pdata_d    = pdata_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;

        if (state_q != IDLE) begin
            edge_d = last_edge ? '0 : edge_q + PRESC_W'(1);
            if (at_s0) samp_d[0] = rx_s;
            if (at_s1) samp_d[1] = rx_s;
        end

        case (state_q)
            IDLE: begin
                edge_d = '0;
                if (!rx_s) begin
                    // The detection cycle is edge 0 of the start bit.
                    state_d    = START;
                    edge_d     = PRESC_W'(1);
                    presc_d    = prescale;
                    par_en_d   = parity_enable;
                    par_type_d = parity_type;
                    bit_d      = '0;
                    par_flag_d = 1'b0;
                end
            end
            START: begin
                if (at_s2) start_v_d = vote;
                if (last_edge) state_d = start_v_q ? IDLE : DATA;
            end
            DATA: begin
                if (at_s2) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
                if (last_edge) begin
                    if (bit_q == BCW'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BCW'(1);
                    end
                end
            end
            PARITY: begin
                if (at_s2) par_flag_d = (vote != ((^shift_q) ^ par_type_q));
                if (last_edge) state_d = STOP;
            end
            STOP: begin
                // Leave at mid stop bit so that a start bit that follows at
                // once is not missed.
                if (at_s2) begin
                    state_d = IDLE;
                    edge_d  = '0;
                    if (!vote) begin
                        se_d = 1'b1;
                    end else if (par_flag_q) begin
                        pe_d = 1'b1;
                    end else begin
                        dv_d    = 1'b1;
                        pdata_d = shift_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                edge_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q     <= '1;
            state_q    <= IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            samp_q     <= '1;
            start_v_q  <= 1'b1;
            shift_q    <= '0;
            par_flag_q <= 1'b0;
            pdata_q    <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], RX_IN};
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            samp_q     <= samp_d;
            start_v_q  <= start_v_d;
            shift_q    <= shift_d;
            par_flag_q <= par_flag_d;
            pdata_q    <= pdata_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign P_DATA       = pdata_q;
    assign data_valid   = dv_q;
    assign parity_error = pe_q;
    assign stop_error   = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx. The tasks drive serial frames and push
//   the expected result of each frame to a scoreboard queue. A monitor pops
//   one entry for every pulse the receiver produces and compares it.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] prescale;
    logic       parity_enable;
    logic       parity_type;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;

    uart_rx #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_IN         (RX_IN),
        .prescale      (prescale),
        .parity_enable (parity_enable),
        .parity_type   (parity_type),
        .P_DATA        (P_DATA),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .stop_error    (stop_error)
    );

    always #5 CLK = ~CLK;

    // kind = {stop_error, parity_error, data_valid}
    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
    } ev_t;

    localparam logic [2:0] K_VALID = 3'b001;
    localparam logic [2:0] K_PAR   = 3'b010;
    localparam logic [2:0] K_STOP  = 3'b100;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] last_good = 8'h00;

    // Scoreboard: compare every output pulse against the oldest expectation.
    always @(negedge CLK) begin
        if (RST && (data_valid || parity_error || stop_error)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got kind=%b P_DATA=%h, required no pulse",
                         {stop_error, parity_error, data_valid}, P_DATA);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if ({stop_error, parity_error, data_valid} !== e.kind || P_DATA !== e.data) begin
                    n_fail++;
                    $display("FAIL frame_result: got kind=%b P_DATA=%h, required kind=%b P_DATA=%h",
                             {stop_error, parity_error, data_valid}, P_DATA, e.kind, e.data);
                end
            end
        end
    end

    task automatic drive_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                              input logic pbit, input logic stopb);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(stopb, p);
        RX_IN = 1'b1;
    endtask

    task automatic set_cfg(input int p, input logic pen, input logic ptype);
        prescale      = 6'(p);
        parity_enable = pen;
        parity_type   = ptype;
    endtask

    task automatic push_exp(input logic [2:0] kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        RST   = 1'b0;
        RX_IN = 1'b1;
        set_cfg(8, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        n_checks++;
        if (P_DATA !== 8'h00) begin
            n_fail++; $display("FAIL reset_pdata: got %h, required 00", P_DATA);
        end
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b, required 0", data_valid);
        end
        n_checks++;
        if (parity_error !== 1'b0) begin
            n_fail++; $display("FAIL reset_parity: got %b, required 0", parity_error);
        end
        n_checks++;
        if (stop_error !== 1'b0) begin
            n_fail++; $display("FAIL reset_stop: got %b, required 0", stop_error);
        end
        RST = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_even_parity;
        set_cfg(8, 1'b1, 1'b0);
        push_exp(K_VALID, 8'hAA);
        send_frame(8'hAA, 8, 1'b1, 1'b0, 1'b1);
        last_good = 8'hAA;
        repeat (16) @(negedge CLK);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL even_parity_drain: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (P_DATA !== 8'hAA) begin
            n_fail++; $display("FAIL even_parity_pdata: got %h, required aa", P_DATA);
        end
    endtask

    task automatic test_parity_error;
        set_cfg(16, 1'b1, 1'b1);
        // 0x3C has four ones, so odd parity needs a 1; a 0 is the wrong bit.
        push_exp(K_PAR, last_good);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1);
        repeat (32) @(negedge CLK);
        n_checks++;
        if (P_DATA !== 8'hAA) begin
            n_fail++; $display("FAIL parity_err_hold: got %h, required aa", P_DATA);
        end
        push_exp(K_VALID, 8'h3C);
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1);
        last_good = 8'h3C;
        repeat (32) @(negedge CLK);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL parity_drain: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_stop_error;
        set_cfg(8, 1'b0, 1'b0);
        push_exp(K_STOP, last_good);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0);
        repeat (24) @(negedge CLK);
        n_checks++;
        if (P_DATA !== 8'h3C) begin
            n_fail++; $display("FAIL stop_err_hold: got %h, required 3c", P_DATA);
        end
        push_exp(K_VALID, 8'h81);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
        last_good = 8'h81;
        repeat (16) @(negedge CLK);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL stop_drain: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (P_DATA !== 8'h81) begin
            n_fail++; $display("FAIL stop_next_pdata: got %h, required 81", P_DATA);
        end
    endtask

    task automatic test_glitch;
        set_cfg(16, 1'b0, 1'b0);
        RX_IN = 1'b0;
        repeat (4) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (48) @(negedge CLK);
        n_checks++;
        if (P_DATA !== 8'h81) begin
            n_fail++; $display("FAIL glitch_hold: got %h, required 81", P_DATA);
        end
        // A clean frame right after shows the receiver went back to idle.
        push_exp(K_VALID, 8'hC3);
        send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b1);
        last_good = 8'hC3;
        repeat (32) @(negedge CLK);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL glitch_drain: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] seq [3];
        seq[0] = 8'h55; seq[1] = 8'hA5; seq[2] = 8'hFF;
        set_cfg(32, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push_exp(K_VALID, seq[i]);
            send_frame(seq[i], 32, 1'b0, 1'b0, 1'b1);
        end
        last_good = 8'hFF;
        repeat (64) @(negedge CLK);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        d = 8'hB7;
        set_cfg(8, 1'b0, 1'b0);
        drive_bit(1'b0, 8);
        for (int i = 0; i < 3; i++) drive_bit(d[i], 8);
        RX_IN = d[3];
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        #1;
        n_checks++;
        if (P_DATA !== 8'h00) begin
            n_fail++; $display("FAIL mid_reset_pdata: got %h, required 00", P_DATA);
        end
        n_checks++;
        if ({stop_error, parity_error, data_valid} !== 3'b000) begin
            n_fail++; $display("FAIL mid_reset_pulses: got %b, required 000",
                               {stop_error, parity_error, data_valid});
        end
        last_good = 8'h00;
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (16) @(negedge CLK);
        push_exp(K_VALID, 8'h12);
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1);
        last_good = 8'h12;
        repeat (16) @(negedge CLK);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL mid_reset_drain: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (P_DATA !== 8'h12) begin
            n_fail++; $display("FAIL mid_reset_next: got %h, required 12", P_DATA);
        end
    endtask

    // Transmitter model on the same clock: random words, prescale and parity.
    task automatic test_loopback;
        int         p;
        logic       pen, ptype;
        logic [7:0] d;
        for (int n = 0; n < 8; n++) begin
            case ($urandom_range(2, 0))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            pen   = 1'($urandom_range(1, 0));
            ptype = 1'($urandom_range(1, 0));
            d     = 8'($urandom_range(255, 0));
            set_cfg(p, pen, ptype);
            push_exp(K_VALID, d);
            send_frame(d, p, pen, (^d) ^ ptype, 1'b1);
            last_good = d;
            repeat (p) @(negedge CLK);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL loopback_drain: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (P_DATA !== last_good) begin
            n_fail++; $display("FAIL loopback_pdata: got %h, required %h", P_DATA, last_good);
        end
    endtask

    initial begin
        RST = 1'b0;
        RX_IN = 1'b1;
        prescale = 6'd8;
        parity_enable = 1'b0;
        parity_type = 1'b0;
        @(negedge CLK);
        test_reset;
        test_even_parity;
        test_parity_error;
        test_stop_error;
        test_glitch;
        test_back_to_back;
        test_reset_mid;
        test_loopback;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
